fetch_pc_unit: RTL

Next-PC and instruction-fetch request stage that consumes the branch comparator result from execute. It holds the architectural fetch PC and issues fetch requests over a valid/ready port. On a taken branch or jump it redirects, flushes the younger stages and discards wrong-path responses still in flight. It sits between the EX-stage comparator/immediate path and the instruction memory, and feeds the IF/ID pipeline register.

---
 rtl/fetch_pc_unit.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/fetch_pc_unit.sv
// Fetch PC unit: owns the architectural fetch PC, issues in-order fetch requests and
// redirects on taken branches/jumps, discarding wrong-path responses still in flight.
module fetch_pc_unit #(
  parameter int unsigned     XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     MAX_OUT  = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            ex_valid,
  input  logic            ex_is_branch,
  input  logic            ex_is_jal,
  input  logic            ex_is_jalr,
  input  logic            cmp_res,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_imm,
  input  logic [XLEN-1:0] ex_rs1,
  output logic            if_req_valid,
  output logic [XLEN-1:0] if_req_addr,
  input  logic            if_req_ready,
  input  logic            if_resp_valid,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst_pc,
  output logic            flush,
  output logic            misalign,
  output logic [1:0]      dbg_state
);

  localparam int CW = $clog2(MAX_OUT + 1);
  localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_OUT);
  localparam logic [PW-1:0] LAST_PTR = PW'(MAX_OUT - 1);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_PEND = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pend_q, pend_d;
  logic            held_q, held_d;
  logic            misalign_q, misalign_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   discard_q, discard_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [XLEN-1:0] fifo_q [MAX_OUT];
  logic [XLEN-1:0] fifo_d [MAX_OUT];

  logic            taken;
  logic            fire;
  logic            resp_eff;
  logic            redirect;
  logic            load_pc;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] pc_new;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  // Request handshake: a request transfers on a cycle where if_req_valid and
  // if_req_ready are both high; once valid rises, valid and address hold until that cycle.
  always_comb begin
    taken    = ex_valid && (ex_is_jal || ex_is_jalr || (ex_is_branch && cmp_res));
    jalr_sum = ex_rs1 + ex_imm;
    target   = ex_is_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : ex_pc + ex_imm;

    case (state_q)
      ST_RUN:  if_req_valid = (inflight_q < MAX_CNT) && (!stall || held_q);
      ST_PEND: if_req_valid = 1'b1;
      default: if_req_valid = 1'b0;
    endcase

    if_req_addr = pc_q;
    fire        = if_req_valid && if_req_ready;
    resp_eff    = if_resp_valid && (inflight_q != '0);
    flush       = taken;
    inst_valid  = resp_eff && (discard_q == '0);
    inst_pc     = fifo_q[rd_ptr_q];
    misalign    = misalign_q;
    dbg_state   = state_q;
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_d     = pend_q;
    misalign_d = misalign_q;
    held_d     = if_req_valid && !if_req_ready;
    redirect   = 1'b0;
    load_pc    = 1'b0;
    pc_new     = pc_q;

    case (state_q)
      ST_RUN: begin
        if (taken && if_req_valid && !if_req_ready) begin
          state_d  = ST_PEND;
          pend_d   = target;
          redirect = 1'b1;
        end else if (taken) begin
          load_pc  = 1'b1;
          pc_new   = target;
          redirect = 1'b1;
        end else if (fire) begin
          load_pc = 1'b1;
          pc_new  = pc_q + XLEN'(4);
        end
      end
      ST_PEND: begin
        // A younger redirect overrides the parked target; it wins even on the accept cycle.
        if (taken && !fire) begin
          pend_d   = target;
          redirect = 1'b1;
        end else if (taken) begin
          load_pc  = 1'b1;
          pc_new   = target;
          redirect = 1'b1;
          state_d  = ST_RUN;
        end else if (fire) begin
          load_pc = 1'b1;
          pc_new  = pend_q;
          state_d = ST_RUN;
        end
      end
      default: ;
    endcase

    if (load_pc) begin
      if (pc_new[1:0] != 2'b00) begin
        state_d    = ST_HALT;
        misalign_d = 1'b1;
        redirect   = 1'b0;
      end else begin
        pc_d = pc_new;
      end
    end

    inflight_d = inflight_q + CW'(fire) - CW'(resp_eff);
    if (redirect) begin
      discard_d = inflight_d;
    end else begin
      discard_d = discard_q + CW'(fire && (state_q == ST_PEND))
                - CW'(resp_eff && (discard_q != '0));
    end

    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (fire) begin
      fifo_d[wr_ptr_q] = pc_q;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end
    if (resp_eff) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_PC;
      pend_q     <= '0;
      held_q     <= 1'b0;
      misalign_q <= 1'b0;
      inflight_q <= '0;
      discard_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      held_q     <= held_d;
      misalign_q <= misalign_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Entries are only meaningful between push and pop, so the storage needs no reset.
  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
  end

endmodule
